fpnew_result_buffer: RTL and testbench

- Output-side stage directly downstream of the opgroup block.
- Accepts arbitrated results (result, status, extension bit, tag) over a valid/ready handshake and holds them in a small registered FIFO.
- Presents them to the FPU top-level output port, decoupling the opgroup arbiter from core back-pressure.
- Optionally accumulates sticky IEEE exception flags over all retired results.

---
 rtl/fpnew_result_buffer.sv | 123 ++++++++++++
 tb/tb_fpnew_result_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_result_buffer.sv
// Registered result FIFO between the opgroup arbiter and the FPU output port. A push shows on out_valid_o 1 cycle later,
// and in_ready_o comes only from the occupancy register. FPNEW_RESBUF_STICKY_FLAGS_EN adds sticky IEEE flag accumulation.
module fpnew_result_buffer #(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 4,
  parameter type         TagType = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [Width-1:0]           in_result_i,
  input  logic [4:0]                 in_status_i,
  input  logic                       in_ext_bit_i,
  input  TagType                     in_tag_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [Width-1:0]           out_result_o,
  output logic [4:0]                 out_status_o,
  output logic                       out_ext_bit_o,
  output TagType                     out_tag_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       busy_o,
  input  logic                       fflags_clr_i,
  output logic [4:0]                 fflags_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [Width-1:0] result;
    logic [4:0]       status;
    logic             ext_bit;
    TagType           tag;
  } entry_t;

  entry_t            mem_q [Depth];
  entry_t            in_entry;
  entry_t            head;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              push;
  logic              pop;

  assign in_ready_o  = (cnt_q != CntW'(Depth));
  assign out_valid_o = (cnt_q != '0);
  assign usage_o     = cnt_q;
  assign busy_o      = out_valid_o;

  // Flush wins over both handshakes, so neither side sees a transfer that cycle.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign in_entry = '{result: in_result_i, status: in_status_i, ext_bit: in_ext_bit_i, tag: in_tag_i};
  assign head     = mem_q[rd_ptr_q];

  assign out_result_o  = head.result;
  assign out_status_o  = head.status;
  assign out_ext_bit_o = head.ext_bit;
  assign out_tag_o     = head.tag;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: it is only observed while out_valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

`ifdef FPNEW_RESBUF_STICKY_FLAGS_EN
  logic [4:0] fflags_q, fflags_d;

  // A clear in the same cycle as a pop leaves exactly the popped status.
  always_comb begin
    fflags_d = fflags_q;
    if (pop)               fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | out_status_o;
    else if (fflags_clr_i) fflags_d = 5'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) fflags_q <= '0;
    else       fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr_i;
  assign fflags_o          = 5'b0;
`endif

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Scoreboard bench for fpnew_result_buffer: tasks drive scenarios, a negedge monitor models occupancy, order and flags.
module tb_fpnew_result_buffer;

  localparam int DEPTH = 4;
`ifdef FPNEW_RESBUF_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk;
  logic        rst_i, flush_i;
  logic [31:0] in_result_i;
  logic [4:0]  in_status_i;
  logic        in_ext_bit_i;
  logic [7:0]  in_tag_i;
  logic        in_valid_i, in_ready_o;
  logic [31:0] out_result_o;
  logic [4:0]  out_status_o;
  logic        out_ext_bit_o;
  logic [7:0]  out_tag_o;
  logic        out_valid_o, out_ready_i;
  logic [2:0]  usage_o;
  logic        busy_o;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  s;
    logic        e;
    logic [7:0]  t;
  } exp_t;

  exp_t       q[$];
  int         mcnt   = 0;
  logic [4:0] mflags = 5'h0;

  fpnew_result_buffer #(.Width(32), .Depth(DEPTH), .TagType(logic [7:0])) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_result_i(in_result_i), .in_status_i(in_status_i), .in_ext_bit_i(in_ext_bit_i),
    .in_tag_i(in_tag_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_result_o(out_result_o), .out_status_o(out_status_o), .out_ext_bit_o(out_ext_bit_o),
    .out_tag_o(out_tag_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .usage_o(usage_o), .busy_o(busy_o), .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are stable from posedge+1 to the next posedge, so negedge sees what the next edge will sample.
  always @(negedge clk) begin
    bit   do_pop, do_push;
    exp_t h;
    if (rst_i) begin
      q.delete();
      mcnt   = 0;
      mflags = 5'h0;
    end else begin
      checks++;
      if (in_ready_o !== (mcnt != DEPTH)) begin
        errors++; $display("FAIL mon_in_ready: got %b want %b", in_ready_o, (mcnt != DEPTH));
      end
      checks++;
      if (out_valid_o !== (mcnt != 0) || busy_o !== (mcnt != 0)) begin
        errors++; $display("FAIL mon_valid_busy: got %b/%b want %b", out_valid_o, busy_o, (mcnt != 0));
      end
      checks++;
      if (usage_o !== 3'(mcnt)) begin
        errors++; $display("FAIL mon_usage: got %0d want %0d", usage_o, mcnt);
      end
      checks++;
      if (fflags_o !== mflags) begin
        errors++; $display("FAIL mon_fflags: got %h want %h", fflags_o, mflags);
      end
      if (flush_i) begin
        q.delete();
        mcnt = 0;
        if (fflags_clr_i && STICKY) mflags = 5'h0;
      end else begin
        do_pop  = out_ready_i && (mcnt != 0);
        do_push = in_valid_i && (mcnt != DEPTH);
        if (do_pop) begin
          h = q.pop_front();
          checks++;
          if ({out_result_o, out_status_o, out_ext_bit_o, out_tag_o} !== {h.r, h.s, h.e, h.t}) begin
            errors++;
            $display("FAIL mon_pop_data: got r=%h s=%h e=%b t=%h want r=%h s=%h e=%b t=%h",
                     out_result_o, out_status_o, out_ext_bit_o, out_tag_o, h.r, h.s, h.e, h.t);
          end
          if (STICKY) mflags = (fflags_clr_i ? 5'h0 : mflags) | h.s;
        end else if (fflags_clr_i && STICKY) begin
          mflags = 5'h0;
        end
        if (do_push) q.push_back('{r: in_result_i, s: in_status_i, e: in_ext_bit_i, t: in_tag_i});
        mcnt = mcnt + int'(do_push) - int'(do_pop);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic [31:0] r, input logic [4:0] s, input logic [7:0] t);
    in_valid_i   = 1'b1;
    in_result_i  = r;
    in_status_i  = s;
    in_ext_bit_i = t[0];
    in_tag_i     = t;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || usage_o !== 3'd0 || busy_o !== 1'b0 || fflags_o !== 5'h0) begin
      errors++;
      $display("FAIL reset_state: got v=%b rdy=%b use=%0d busy=%b ff=%h want 0 1 0 0 00",
               out_valid_o, in_ready_o, usage_o, busy_o, fflags_o);
    end
  endtask

  task automatic test_single();
    drive_in(32'h3F800000, 5'h0, 8'd1);
    #1;
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_no_bypass: got valid=%b want 0", out_valid_o);
    end
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || out_result_o !== 32'h3F800000 || out_tag_o !== 8'd1 || usage_o !== 3'd1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_push: got v=%b r=%h t=%h use=%0d busy=%b want 1 3f800000 01 1 1",
               out_valid_o, out_result_o, out_tag_o, usage_o, busy_o);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checks++;
    if (usage_o !== 3'd0 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_pop: got use=%0d v=%b want 0 0", usage_o, out_valid_o);
    end
  endtask

  task automatic test_fill();
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_in(32'hA000_0000 + 32'(i), 5'h0, 8'(8'h10 + i));
      tick();
    end
    checks++;
    if (usage_o !== 3'd4 || in_ready_o !== 1'b0) begin
      errors++; $display("FAIL fill_full: got use=%0d rdy=%b want 4 0", usage_o, in_ready_o);
    end
    drive_in(32'hA000_0004, 5'h0, 8'h14);
    tick();
    checks++;
    if (usage_o !== 3'd4 || out_tag_o !== 8'h10) begin
      errors++; $display("FAIL fill_held: got use=%0d head=%h want 4 10", usage_o, out_tag_o);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checks++;
    if (usage_o !== 3'd3 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL fill_pop_no_push: got use=%0d rdy=%b want 3 1", usage_o, in_ready_o);
    end
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (usage_o !== 3'd4) begin
      errors++; $display("FAIL fill_fifth_accepted: got use=%0d want 4", usage_o);
    end
    out_ready_i = 1'b1;
    repeat (4) tick();
    out_ready_i = 1'b0;
    checks++;
    if (usage_o !== 3'd0) begin
      errors++; $display("FAIL fill_drain: got use=%0d want 0", usage_o);
    end
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_in(32'hB000_0000 + 32'(i), 5'h0, 8'(i));
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive_in(32'hB000_0000 + 32'(k + 2), 5'h0, 8'(k + 2));
      out_ready_i = 1'b1;
      #1;
      checks++;
      if (out_tag_o !== 8'(k)) begin
        errors++; $display("FAIL b2b_order: got tag=%0d want %0d", out_tag_o, k);
      end
      tick();
      checks++;
      if (usage_o !== 3'd2) begin
        errors++; $display("FAIL b2b_usage: got use=%0d want 2", usage_o);
      end
    end
    in_valid_i = 1'b0;
    tick();
    tick();
    out_ready_i = 1'b0;
    checks++;
    if (usage_o !== 3'd0) begin
      errors++; $display("FAIL b2b_drain: got use=%0d want 0", usage_o);
    end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_in(32'hC000_0000 + 32'(i), 5'h0, 8'(8'h20 + i));
      tick();
    end
    drive_in(32'h0000_DEAD, 5'h0, 8'hEE);
    flush_i = 1'b1;
    tick();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    checks++;
    if (usage_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_state: got use=%0d v=%b rdy=%b want 0 0 1", usage_o, out_valid_o, in_ready_o);
    end
    drive_in(32'h0000_1234, 5'h0, 8'h30);
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (out_result_o !== 32'h0000_1234 || usage_o !== 3'd1) begin
      errors++; $display("FAIL flush_no_ghost: got r=%h use=%0d want 00001234 1", out_result_o, usage_o);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_flags();
    logic [4:0] want;
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    drive_in(32'hD000_0000, 5'h01, 8'h40); tick();
    drive_in(32'hD000_0001, 5'h10, 8'h41); tick();
    drive_in(32'hD000_0002, 5'h04, 8'h42); tick();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    tick();
    out_ready_i = 1'b0;
    want = STICKY ? 5'h11 : 5'h00;
    checks++;
    if (fflags_o !== want) begin
      errors++; $display("FAIL flags_accum: got %h want %h", fflags_o, want);
    end
    fflags_clr_i = 1'b1;
    out_ready_i  = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    out_ready_i  = 1'b0;
    want = STICKY ? 5'h04 : 5'h00;
    checks++;
    if (fflags_o !== want || usage_o !== 3'd0) begin
      errors++; $display("FAIL flags_clr_pop: got ff=%h use=%0d want %h 0", fflags_o, usage_o, want);
    end
    drive_in(32'hD000_0003, 5'h08, 8'h43);
    tick();
    in_valid_i  = 1'b0;
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    checks++;
    if (fflags_o !== want || usage_o !== 3'd0) begin
      errors++; $display("FAIL flags_flush_keep: got ff=%h use=%0d want %h 0", fflags_o, usage_o, want);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] want;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_in(32'hE000_0000 + 32'(i), 5'h02, 8'(8'h50 + i));
      tick();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    want = STICKY ? 5'h02 : 5'h00;
    checks++;
    if (usage_o !== 3'd2 || fflags_o !== want) begin
      errors++; $display("FAIL rstmid_pre: got use=%0d ff=%h want 2 %h", usage_o, fflags_o, want);
    end
    rst_i = 1'b1;
    tick();
    rst_i       = 1'b0;
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || usage_o !== 3'd0 || fflags_o !== 5'h0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_post: got v=%b use=%0d ff=%h rdy=%b want 0 0 00 1", out_valid_o, usage_o, fflags_o, in_ready_o);
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    in_valid_i   = 1'b0;
    in_result_i  = '0;
    in_status_i  = '0;
    in_ext_bit_i = 1'b0;
    in_tag_i     = '0;
    out_ready_i  = 1'b0;
    fflags_clr_i = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_flags();
    test_reset_mid();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
